// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, access
// encodings, register-file write codes and command decode helpers.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_REQ       = 2'd1,
    ST_WAIT_RESP = 2'd2,
    ST_DONE      = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] WE_NONE = 2'b00;
  localparam logic [1:0] WE_WORD = 2'b01;

  // High when the command is misaligned or has no legal encoding.
  function automatic logic cmd_bad(input logic is_store, input logic [2:0] f3,
                                   input logic [1:0] a);
    logic bad;
    case (f3)
      F3_B:    bad = 1'b0;
      F3_H:    bad = a[0];
      F3_W:    bad = (a != 2'b00);
      F3_BU:   bad = is_store;
      F3_HU:   bad = is_store | a[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] a);
    logic [3:0] s;
    case (f3)
      F3_B:    s = 4'b0001 << a;
      F3_H:    s = a[1] ? 4'b1100 : 4'b0011;
      F3_W:    s = 4'b1111;
      default: s = 4'b0000;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/load_align.sv
// Picks the addressed byte/half/word out of a read word and sign- or
// zero-extends it to the full data width.
module load_align
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            addr_lo,
  input  logic [2:0]            funct3,
  output logic [DATA_WIDTH-1:0] data_c
);

  localparam int unsigned BYTE_EXT = DATA_WIDTH - 8;
  localparam int unsigned HALF_EXT = DATA_WIDTH - 16;

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'h00;
    case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    data_c = rdata;
    case (funct3)
      F3_B:    data_c = {{BYTE_EXT{byte_sel[7]}}, byte_sel};
      F3_BU:   data_c = {{BYTE_EXT{1'b0}}, byte_sel};
      F3_H:    data_c = {{HALF_EXT{half_sel[15]}}, half_sel};
      F3_HU:   data_c = {{HALF_EXT{1'b0}}, half_sel};
      default: data_c = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: decodes a command, issues one memory
// request with byte strobes, and writes aligned load data back.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  is_store,
  input  logic [2:0]            funct3,
  input  logic [DATA_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] store_data,
  input  logic [4:0]            rd,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [1:0]            wb_we,
  output logic [4:0]            wb_rd,
  output logic [DATA_WIDTH-1:0] wb_data
);

  localparam int unsigned NUM_B = DATA_WIDTH / 8;
  localparam int unsigned NUM_H = DATA_WIDTH / 16;

  lsu_state_e            state_q, state_d;
  logic                  is_store_q, is_store_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [1:0]            addr_lo_q, addr_lo_d;
  logic [4:0]            rd_q, rd_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [DATA_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]            mem_wstrb_q, mem_wstrb_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [1:0]            wb_we_q, wb_we_d;
  logic [4:0]            wb_rd_q, wb_rd_d;
  logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;
  logic [DATA_WIDTH-1:0] load_c;
  logic [DATA_WIDTH-1:0] store_rep_c;

  load_align #(.DATA_WIDTH(DATA_WIDTH)) u_load_align (
    .rdata   (mem_rdata),
    .addr_lo (addr_lo_q),
    .funct3  (funct3_q),
    .data_c  (load_c)
  );

  always_comb begin
    case (funct3)
      F3_B:    store_rep_c = {NUM_B{store_data[7:0]}};
      F3_H:    store_rep_c = {NUM_H{store_data[15:0]}};
      default: store_rep_c = store_data;
    endcase
  end

  // Next-state and registered-output computation; pulses default low.
  always_comb begin
    state_d     = state_q;
    is_store_d  = is_store_q;
    funct3_d    = funct3_q;
    addr_lo_d   = addr_lo_q;
    rd_d        = rd_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    wb_we_d     = WE_NONE;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;

    case (state_q)
      ST_IDLE: begin
        busy_d    = 1'b0;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
        if (start) begin
          if (cmd_bad(is_store, funct3, addr[1:0])) begin
            err_d = 1'b1;
          end else begin
            state_d     = ST_REQ;
            is_store_d  = is_store;
            funct3_d    = funct3;
            addr_lo_d   = addr[1:0];
            rd_d        = rd;
            mem_req_d   = 1'b1;
            mem_we_d    = is_store;
            mem_addr_d  = {addr[DATA_WIDTH-1:2], 2'b00};
            mem_wdata_d = is_store ? store_rep_c : '0;
            mem_wstrb_d = is_store ? store_strb(funct3, addr[1:0]) : 4'b0000;
            busy_d      = 1'b1;
          end
        end
      end
      ST_REQ: begin
        if (mem_ready) begin
          state_d     = ST_DONE;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_wstrb_d = 4'b0000;
          done_d      = 1'b1;
          wb_rd_d     = rd_q;
          if (!is_store_q) begin
            wb_data_d = load_c;
            if (rd_q != 5'd0) wb_we_d = WE_WORD;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d     = ST_IDLE;
        busy_d      = 1'b0;
        mem_req_d   = 1'b0;
        mem_we_d    = 1'b0;
        mem_wstrb_d = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      is_store_q  <= 1'b0;
      funct3_q    <= 3'b000;
      addr_lo_q   <= 2'b00;
      rd_q        <= 5'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= 4'b0000;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      wb_we_q     <= WE_NONE;
      wb_rd_q     <= 5'd0;
      wb_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      is_store_q  <= is_store_d;
      funct3_q    <= funct3_d;
      addr_lo_q   <= addr_lo_d;
      rd_q        <= rd_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      wb_we_q     <= wb_we_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign wb_we     = wb_we_q;
  assign wb_rd     = wb_rd_q;
  assign wb_data   = wb_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed, table-driven bench for load_store_unit plus hand-written
// stall and mid-transaction reset sequences.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic [4:0]  rd;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  load_store_unit #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .is_store(is_store), .funct3(funct3),
    .addr(addr), .store_data(store_data), .rd(rd), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .err(err), .wb_we(wb_we), .wb_rd(wb_rd),
    .wb_data(wb_data)
  );

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] sdata;
    logic [4:0]  rdi;
    logic [31:0] rdata;
    logic        x_err;
    logic [3:0]  x_strb;
    logic [31:0] x_wdata;
    logic [1:0]  x_wbwe;
    logic [31:0] x_wbdata;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_cmd(input logic st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] sd, input logic [4:0] r);
    start = 1'b1; is_store = st; funct3 = f3; addr = a; store_data = sd; rd = r;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("v%0d", idx);
    @(negedge clk);
    drive_cmd(v.st, v.f3, v.a, v.sdata, v.rdi);
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_err"}, 32'(err), 32'(v.x_err));
    chk({tag, "_req"}, 32'(mem_req), 32'(!v.x_err));
    chk({tag, "_busy"}, 32'(busy), 32'(!v.x_err));
    if (!v.x_err) begin
      chk({tag, "_we"}, 32'(mem_we), 32'(v.st));
      chk({tag, "_addr"}, mem_addr, {v.a[31:2], 2'b00});
      chk({tag, "_strb"}, 32'(mem_wstrb), 32'(v.x_strb));
      if (v.st) chk({tag, "_wdata"}, mem_wdata, v.x_wdata);
      mem_ready = 1'b1;
      mem_rdata = v.rdata;
      @(negedge clk);
      mem_ready = 1'b0;
      mem_rdata = 32'h0;
      chk({tag, "_done"}, 32'(done), 32'd1);
      chk({tag, "_doneerr"}, 32'(err), 32'd0);
      chk({tag, "_reqoff"}, 32'(mem_req), 32'd0);
      chk({tag, "_wbwe"}, 32'(wb_we), 32'(v.x_wbwe));
      if (v.x_wbwe == 2'b01) begin
        chk({tag, "_wbrd"}, 32'(wb_rd), 32'(v.rdi));
        chk({tag, "_wbdata"}, wb_data, v.x_wbdata);
      end
      @(negedge clk);
      chk({tag, "_done_pulse"}, 32'(done), 32'd0);
      chk({tag, "_idle"}, 32'(busy), 32'd0);
      chk({tag, "_wbwe_off"}, 32'(wb_we), 32'd0);
    end else begin
      @(negedge clk);
      chk({tag, "_err_pulse"}, 32'(err), 32'd0);
      chk({tag, "_noreq"}, 32'(mem_req), 32'd0);
    end
  endtask

  function automatic vec_t mk(input logic st, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] sd, input logic [4:0] r, input logic [31:0] rdt,
                              input logic xe, input logic [3:0] xs, input logic [31:0] xw,
                              input logic [1:0] xwe, input logic [31:0] xwd);
    vec_t v;
    v.st = st; v.f3 = f3; v.a = a; v.sdata = sd; v.rdi = r; v.rdata = rdt;
    v.x_err = xe; v.x_strb = xs; v.x_wdata = xw; v.x_wbwe = xwe; v.x_wbdata = xwd;
    return v;
  endfunction

  logic [31:0] snap_addr, snap_wdata;

  initial begin
    rst = 1'b1; start = 1'b0; is_store = 1'b0; funct3 = 3'b000; addr = 32'h0;
    store_data = 32'h0; rd = 5'd0; mem_ready = 1'b0; mem_rdata = 32'h0;

    //          st   f3      addr          sdata         rd     rdata         err  strb     wdata         wbwe   wbdata
    vecs.push_back(mk(1'b0, 3'b010, 32'h0000_0100, 32'h0,        5'd5,  32'hDEAD_BEEF, 1'b0, 4'b0000, 32'h0,        2'b01, 32'hDEAD_BEEF));
    vecs.push_back(mk(1'b0, 3'b000, 32'h0000_0103, 32'h0,        5'd6,  32'h80FF_FFFF, 1'b0, 4'b0000, 32'h0,        2'b01, 32'hFFFF_FF80));
    vecs.push_back(mk(1'b0, 3'b100, 32'h0000_0103, 32'h0,        5'd7,  32'h80FF_FFFF, 1'b0, 4'b0000, 32'h0,        2'b01, 32'h0000_0080));
    vecs.push_back(mk(1'b1, 3'b001, 32'h0000_0102, 32'h1234_ABCD, 5'd8, 32'h0,        1'b0, 4'b1100, 32'hABCD_ABCD, 2'b00, 32'h0));
    vecs.push_back(mk(1'b0, 3'b010, 32'h0000_0101, 32'h0,        5'd9,  32'h0,        1'b1, 4'b0000, 32'h0,        2'b00, 32'h0));
    vecs.push_back(mk(1'b1, 3'b000, 32'h0000_0101, 32'h0000_00A5, 5'd1, 32'h0,        1'b0, 4'b0010, 32'hA5A5_A5A5, 2'b00, 32'h0));
    vecs.push_back(mk(1'b1, 3'b010, 32'h0000_0200, 32'h1122_3344, 5'd2, 32'h0,        1'b0, 4'b1111, 32'h1122_3344, 2'b00, 32'h0));
    vecs.push_back(mk(1'b1, 3'b001, 32'h0000_0100, 32'h0000_BEEF, 5'd3, 32'h0,        1'b0, 4'b0011, 32'hBEEF_BEEF, 2'b00, 32'h0));
    vecs.push_back(mk(1'b0, 3'b001, 32'h0000_0102, 32'h0,        5'd10, 32'h8001_7FFF, 1'b0, 4'b0000, 32'h0,        2'b01, 32'hFFFF_8001));
    vecs.push_back(mk(1'b0, 3'b101, 32'h0000_0100, 32'h0,        5'd11, 32'h1234_F00D, 1'b0, 4'b0000, 32'h0,        2'b01, 32'h0000_F00D));
    vecs.push_back(mk(1'b0, 3'b000, 32'h0000_0102, 32'h0,        5'd12, 32'h0055_0000, 1'b0, 4'b0000, 32'h0,        2'b01, 32'h0000_0055));
    vecs.push_back(mk(1'b0, 3'b010, 32'h0000_0104, 32'h0,        5'd0,  32'hCAFE_F00D, 1'b0, 4'b0000, 32'h0,        2'b00, 32'h0));
    vecs.push_back(mk(1'b1, 3'b001, 32'h0000_0103, 32'h0,        5'd0,  32'h0,        1'b1, 4'b0000, 32'h0,        2'b00, 32'h0));
    vecs.push_back(mk(1'b1, 3'b100, 32'h0000_0100, 32'h0,        5'd0,  32'h0,        1'b1, 4'b0000, 32'h0,        2'b00, 32'h0));
    vecs.push_back(mk(1'b0, 3'b011, 32'h0000_0100, 32'h0,        5'd4,  32'h0,        1'b1, 4'b0000, 32'h0,        2'b00, 32'h0));
    vecs.push_back(mk(1'b0, 3'b101, 32'h0000_0101, 32'h0,        5'd4,  32'h0,        1'b1, 4'b0000, 32'h0,        2'b00, 32'h0));

    repeat (2) @(negedge clk);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wstrb", 32'(mem_wstrb), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wbwe", 32'(wb_we), 32'd0);
    rst = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Stalled store: outputs must hold, a start during the stall is ignored.
    @(negedge clk);
    drive_cmd(1'b1, 3'b010, 32'h0000_0300, 32'h5566_7788, 5'd0);
    @(negedge clk);
    start = 1'b0;
    chk("stall_req0", 32'(mem_req), 32'd1);
    snap_addr = 32'h0000_0300;
    snap_wdata = 32'h5566_7788;
    for (int c = 0; c < 5; c++) begin
      if (c == 2) drive_cmd(1'b0, 3'b000, 32'h0000_0777, 32'hFFFF_FFFF, 5'd9);
      @(negedge clk);
      start = 1'b0;
      chk($sformatf("stall_req_c%0d", c), 32'(mem_req), 32'd1);
      chk($sformatf("stall_we_c%0d", c), 32'(mem_we), 32'd1);
      chk($sformatf("stall_addr_c%0d", c), mem_addr, snap_addr);
      chk($sformatf("stall_wdata_c%0d", c), mem_wdata, snap_wdata);
      chk($sformatf("stall_strb_c%0d", c), 32'(mem_wstrb), 32'hF);
      chk($sformatf("stall_done_c%0d", c), 32'(done), 32'd0);
    end
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    chk("stall_done", 32'(done), 32'd1);
    chk("stall_wbwe", 32'(wb_we), 32'd0);
    @(negedge clk);
    chk("stall_after_busy", 32'(busy), 32'd0);
    chk("stall_after_req", 32'(mem_req), 32'd0);

    // Reset while waiting for mem_ready aborts the access.
    @(negedge clk);
    drive_cmd(1'b0, 3'b010, 32'h0000_0400, 32'h0, 5'd15);
    @(negedge clk);
    start = 1'b0;
    chk("abort_req_pre", 32'(mem_req), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("abort_req", 32'(mem_req), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    mem_ready = 1'b1;
    mem_rdata = 32'h1111_1111;
    @(negedge clk);
    rst = 1'b0;
    mem_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("abort_done_c%0d", c), 32'(done), 32'd0);
      chk($sformatf("abort_wbwe_c%0d", c), 32'(wb_we), 32'd0);
    end

    // First command after reset is taken immediately.
    drive_cmd(1'b0, 3'b010, 32'h0000_0500, 32'h0, 5'd20);
    @(negedge clk);
    start = 1'b0;
    chk("post_rst_req", 32'(mem_req), 32'd1);
    mem_ready = 1'b1;
    mem_rdata = 32'h0BAD_F00D;
    @(negedge clk);
    mem_ready = 1'b0;
    chk("post_rst_done", 32'(done), 32'd1);
    chk("post_rst_wbdata", wb_data, 32'h0BAD_F00D);
    chk("post_rst_wbrd", 32'(wb_rd), 32'd20);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  always @(negedge clk) begin
    if (err && done) begin
      n_fail++;
      $display("FAIL err_done_overlap: got err=1 done=1 expected not both");
    end
  end

endmodule
